// File: rtl/mult_div_unit.sv
// Sequential signed multiply / divide unit.
// Multiply uses radix-2 Booth over a {acc, qreg, qm1} shift register.
// Divide uses restoring division on operand magnitudes.
// Either operation takes WIDTH iterations plus one write-back edge, then one DONE cycle.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, MULT, DIV, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] acc;      // Booth A / partial remainder
  logic [WIDTH-1:0] qreg;     // Booth Q / dividend-then-quotient
  logic [WIDTH-1:0] mreg;     // multiplicand / divisor magnitude
  logic             qm1;      // Booth q-1 bit
  logic [CW-1:0]    cnt;
  logic             neg_q, neg_r, dz;

  logic             accept, accept_dz, last_iter;
  logic [WIDTH:0]   a_ext, m_ext, booth_sum;
  logic [WIDTH:0]   div_shift, div_diff;
  logic             div_ge;
  logic [WIDTH-1:0] abs_a, abs_b;

  assign accept    = (state == IDLE) && start;
  assign accept_dz = accept && op && (operand_b == '0);
  assign last_iter = (cnt == CW'(WIDTH));
  assign abs_a     = operand_a[WIDTH-1] ? -operand_a : operand_a;
  assign abs_b     = operand_b[WIDTH-1] ? -operand_b : operand_b;

  // Booth step: add/sub in WIDTH+1 bits so the shift keeps the true sign even
  // when the multiplicand is the most negative value.
  always_comb begin
    a_ext = {acc[WIDTH-1], acc};
    m_ext = {mreg[WIDTH-1], mreg};
    booth_sum = a_ext;
    case ({qreg[0], qm1})
      2'b01:   booth_sum = a_ext + m_ext;
      2'b10:   booth_sum = a_ext - m_ext;
      default: booth_sum = a_ext;
    endcase
  end

  // Restoring step: shift next dividend bit into remainder, trial-subtract divisor.
  always_comb begin
    div_shift = {acc, qreg[WIDTH-1]};
    div_diff  = div_shift - {1'b0, mreg};
    div_ge    = ~div_diff[WIDTH];
  end

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic; DONE always lasts a single cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) begin
          if (op && (operand_b == '0)) state_nxt = DONE;
          else if (op)                 state_nxt = DIV;
          else                         state_nxt = MULT;
        end
      end
      MULT:    if (last_iter) state_nxt = DONE;
      DIV:     if (last_iter) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: latch operands on accept, iterate, write hi/lo on the final edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      acc   <= '0;
      qreg  <= '0;
      mreg  <= '0;
      qm1   <= 1'b0;
      cnt   <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      dz    <= 1'b0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      if (accept) begin
        cnt   <= '0;
        qm1   <= 1'b0;
        acc   <= '0;
        dz    <= accept_dz;
        neg_q <= operand_a[WIDTH-1] ^ operand_b[WIDTH-1];
        neg_r <= operand_a[WIDTH-1];
        if (op) begin
          qreg <= abs_a;
          mreg <= abs_b;
        end else begin
          qreg <= operand_a;
          mreg <= operand_b;
        end
      end else if (state == MULT) begin
        if (last_iter) begin
          hi <= acc;
          lo <= qreg;
        end else begin
          acc  <= booth_sum[WIDTH:1];
          qreg <= {booth_sum[0], qreg[WIDTH-1:1]};
          qm1  <= qreg[0];
          cnt  <= cnt + 1'b1;
        end
      end else if (state == DIV) begin
        if (last_iter) begin
          // Quotient truncates toward zero, remainder follows the dividend.
          lo <= neg_q ? -qreg : qreg;
          hi <= neg_r ? -acc  : acc;
        end else begin
          acc  <= div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
          qreg <= {qreg[WIDTH-2:0], div_ge};
          cnt  <= cnt + 1'b1;
        end
      end
    end
  end

  // Status outputs decoded from state.
  always_comb begin
    busy     = (state == MULT) || (state == DIV);
    done     = (state == DONE);
    div_zero = (state == DONE) && dz;
  end

endmodule
